// File: rtl/uart_tx_fifo_drain.sv
// Drains bytes from the UART export FIFO and serialises each one as an 8N1/8N2 frame, LSB first.
// Every output is a flop loaded from next-state values, so no input reaches a pin combinationally.
module uart_tx_fifo_drain #(
  parameter int CLKS_PER_BIT = 16,
  parameter int STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       fifo_empty,
  input  logic [7:0] fifo_data,
  output logic       fifo_rd,
  output logic       tx,
  output logic       busy,
  output logic       tx_done
);

  localparam int STOP_LEN = STOP_BITS * CLKS_PER_BIT;
  localparam int CNT_W    = $clog2(STOP_LEN);

  localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] STOP_LAST = CNT_W'(STOP_LEN - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_LOAD  = 3'd2,
    ST_START = 3'd3,
    ST_DATA  = 3'd4,
    ST_STOP  = 3'd5
  } state_t;

  state_t           state_r, state_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic [2:0]       bit_idx_r, bit_idx_s;
  logic [7:0]       shift_r, shift_s;
  logic             tx_r, tx_s;
  logic             fifo_rd_r, fifo_rd_s;
  logic             busy_r, busy_s;
  logic             tx_done_r, tx_done_s;
  logic             start_ok_s;

  assign start_ok_s = enable & ~fifo_empty;

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_IDLE;
      cnt_r     <= CNT_ZERO;
      bit_idx_r <= 3'd0;
      shift_r   <= 8'h00;
      tx_r      <= 1'b1;
      fifo_rd_r <= 1'b0;
      busy_r    <= 1'b0;
      tx_done_r <= 1'b0;
    end else begin
      state_r   <= state_s;
      cnt_r     <= cnt_s;
      bit_idx_r <= bit_idx_s;
      shift_r   <= shift_s;
      tx_r      <= tx_s;
      fifo_rd_r <= fifo_rd_s;
      busy_r    <= busy_s;
      tx_done_r <= tx_done_s;
    end
  end

  // Next-state, baud counter, bit index and shift register.
  always_comb begin
    state_s   = state_r;
    cnt_s     = cnt_r;
    bit_idx_s = bit_idx_r;
    shift_s   = shift_r;
    case (state_r)
      ST_IDLE: begin
        if (start_ok_s) begin
          state_s = ST_READ;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_READ: begin
        state_s = ST_LOAD;
      end
      ST_LOAD: begin
        // The FIFO presents the popped byte from the edge that ends READ.
        shift_s = fifo_data;
        cnt_s   = CNT_ZERO;
        state_s = ST_START;
      end
      ST_START: begin
        if (cnt_r == BIT_LAST) begin
          cnt_s     = CNT_ZERO;
          bit_idx_s = 3'd0;
          state_s   = ST_DATA;
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end
      ST_DATA: begin
        if (cnt_r == BIT_LAST) begin
          cnt_s   = CNT_ZERO;
          shift_s = {1'b0, shift_r[7:1]};
          if (bit_idx_r == 3'd7) begin
            bit_idx_s = 3'd0;
            state_s   = ST_STOP;
          end else begin
            bit_idx_s = bit_idx_r + 3'd1;
          end
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end
      ST_STOP: begin
        if (cnt_r == STOP_LAST) begin
          cnt_s = CNT_ZERO;
          if (start_ok_s) begin
            state_s = ST_READ;
          end else begin
            state_s = ST_IDLE;
          end
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end
      default: begin
        state_s   = ST_IDLE;
        cnt_s     = CNT_ZERO;
        bit_idx_s = 3'd0;
        shift_s   = 8'h00;
      end
    endcase
  end

  // Output values for the coming cycle, derived from the next state.
  always_comb begin
    tx_s = 1'b1;
    case (state_s)
      ST_START: tx_s = 1'b0;
      ST_DATA:  tx_s = shift_s[0];
      default:  tx_s = 1'b1;
    endcase
    fifo_rd_s = (state_s == ST_READ);
    busy_s    = (state_s != ST_IDLE);
    tx_done_s = (state_s == ST_STOP) && (cnt_s == STOP_LAST);
  end

  assign tx      = tx_r;
  assign fifo_rd = fifo_rd_r;
  assign busy    = busy_r;
  assign tx_done = tx_done_r;

endmodule

// File: tb/tb_uart_tx_fifo_drain.sv
// Scoreboard bench: byte FIFO models feed two drain instances (8N1 @16 clk/bit, 8N2 @4 clk/bit)
// and each decoded frame is compared against the byte queued when it was pushed.
module tb_uart_tx_fifo_drain;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       enable_a = 1'b0, enable_b = 1'b0;
  logic       fifo_empty_a, fifo_empty_b;
  logic [7:0] fifo_data_a = 8'h00, fifo_data_b = 8'h00;
  logic       fifo_rd_a, tx_a, busy_a, tx_done_a;
  logic       fifo_rd_b, tx_b, busy_b, tx_done_b;

  int compared = 0;
  int mismatched = 0;

  logic [7:0] mem_a [0:255];
  logic [7:0] mem_b [0:255];
  int wr_a = 0, rd_a = 0, wr_b = 0, rd_b = 0;
  int underflow_a = 0, underflow_b = 0;
  logic [7:0] exp_a [$];
  logic [7:0] exp_b [$];

  logic tx_tr   [0:511];
  logic done_tr [0:511];
  logic rd_tr   [0:511];
  logic busy_tr [0:511];

  always #5 clk = ~clk;

  uart_tx_fifo_drain #(.CLKS_PER_BIT(16), .STOP_BITS(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .enable(enable_a), .fifo_empty(fifo_empty_a),
    .fifo_data(fifo_data_a), .fifo_rd(fifo_rd_a), .tx(tx_a), .busy(busy_a), .tx_done(tx_done_a)
  );

  uart_tx_fifo_drain #(.CLKS_PER_BIT(4), .STOP_BITS(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .enable(enable_b), .fifo_empty(fifo_empty_b),
    .fifo_data(fifo_data_b), .fifo_rd(fifo_rd_b), .tx(tx_b), .busy(busy_b), .tx_done(tx_done_b)
  );

  assign fifo_empty_a = (wr_a == rd_a);
  assign fifo_empty_b = (wr_b == rd_b);

  // Registered-output FIFO models: data appears from the edge that ends the read cycle.
  always @(posedge clk) begin
    if (fifo_rd_a) begin
      if (wr_a == rd_a) underflow_a <= underflow_a + 1;
      else begin
        fifo_data_a <= mem_a[rd_a[7:0]];
        rd_a <= rd_a + 1;
      end
    end
    if (fifo_rd_b) begin
      if (wr_b == rd_b) underflow_b <= underflow_b + 1;
      else begin
        fifo_data_b <= mem_b[rd_b[7:0]];
        rd_b <= rd_b + 1;
      end
    end
  end

  task automatic push_a(input logic [7:0] b);
    mem_a[wr_a[7:0]] = b;
    exp_a.push_back(b);
    wr_a = wr_a + 1;
  endtask

  task automatic push_b(input logic [7:0] b);
    mem_b[wr_b[7:0]] = b;
    exp_b.push_back(b);
    wr_b = wr_b + 1;
  endtask

  // Waits (bounded) for a read strobe; trace index 0 is the READ cycle.
  task automatic capture(input bit sel, input int len, output bit found);
    found = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if ((sel ? fifo_rd_b : fifo_rd_a) === 1'b1) begin
        found = 1'b1;
        break;
      end
    end
    if (found) begin
      for (int i = 0; i < len; i++) begin
        if (i > 0) @(negedge clk);
        tx_tr[i]   = sel ? tx_b : tx_a;
        done_tr[i] = sel ? tx_done_b : tx_done_a;
        rd_tr[i]   = sel ? fifo_rd_b : fifo_rd_a;
        busy_tr[i] = sel ? busy_b : busy_a;
      end
    end
  endtask

  function automatic logic [7:0] decode(input int base, input int cpb);
    logic [7:0] d;
    for (int k = 0; k < 8; k++) d[k] = tx_tr[base + cpb * (k + 1) + cpb / 2];
    return d;
  endfunction

  function automatic int count_rd(input int len);
    int n = 0;
    for (int i = 0; i < len; i++) if (rd_tr[i] === 1'b1) n++;
    return n;
  endfunction

  function automatic int count_done(input int len);
    int n = 0;
    for (int i = 0; i < len; i++) if (done_tr[i] === 1'b1) n++;
    return n;
  endfunction

  task automatic test_reset();
    enable_a = 1'b1;
    enable_b = 1'b0;
    push_a(8'hA5);
    #1 rst_n = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      compared++;
      if ({tx_a, fifo_rd_a, busy_a, tx_done_a} !== 4'b1000) begin
        mismatched++;
        $display("FAIL reset_a: cycle %0d tx/rd/busy/done=%b want 1000", i, {tx_a, fifo_rd_a, busy_a, tx_done_a});
      end
      compared++;
      if ({tx_b, fifo_rd_b, busy_b, tx_done_b} !== 4'b1000) begin
        mismatched++;
        $display("FAIL reset_b: cycle %0d tx/rd/busy/done=%b want 1000", i, {tx_b, fifo_rd_b, busy_b, tx_done_b});
      end
    end
    rst_n = 1'b1;
  endtask

  task automatic test_single_byte();
    bit found;
    logic [7:0] e;
    logic lvl;
    int bad;
    capture(1'b0, 170, found);
    compared++;
    if (!found || exp_a.size() == 0) begin
      mismatched++;
      $display("FAIL single_rd_seen: found=%0d queued=%0d want 1 and >0", found, exp_a.size());
      return;
    end
    e = exp_a.pop_front();
    compared++;
    if (count_rd(170) != 1) begin
      mismatched++;
      $display("FAIL single_rd_count: got %0d pulses want 1", count_rd(170));
    end
    compared++;
    if ({tx_tr[0], tx_tr[1]} !== 2'b11) begin
      mismatched++;
      $display("FAIL single_lead: tx in READ/LOAD=%b want 11", {tx_tr[0], tx_tr[1]});
    end
    for (int p = 0; p < 10; p++) begin
      lvl = (p == 0) ? 1'b0 : (p == 9) ? 1'b1 : e[p-1];
      bad = -1;
      for (int s = 0; s < 16; s++) if (tx_tr[2 + 16 * p + s] !== lvl) bad = s;
      compared++;
      if (bad >= 0) begin
        mismatched++;
        $display("FAIL single_level: period %0d sample %0d got %b want %b", p, bad, tx_tr[2 + 16 * p + bad], lvl);
      end
    end
    compared++;
    if (count_done(170) != 1 || done_tr[161] !== 1'b1) begin
      mismatched++;
      $display("FAIL single_tx_done: count=%0d at_160=%b want 1 and 1", count_done(170), done_tr[161]);
    end
    compared++;
    if ({busy_tr[161], busy_tr[162], tx_tr[165]} !== 3'b101) begin
      mismatched++;
      $display("FAIL single_idle: busy_last/busy_after/tx=%b want 101", {busy_tr[161], busy_tr[162], tx_tr[165]});
    end
    compared++;
    if (decode(2, 16) !== e) begin
      mismatched++;
      $display("FAIL single_byte: got %h want %h", decode(2, 16), e);
    end
  endtask

  task automatic test_back_to_back();
    bit found;
    logic [7:0] e;
    push_a(8'h01);
    push_a(8'h02);
    push_a(8'h03);
    capture(1'b0, 3 * 162 + 8, found);
    compared++;
    if (!found || exp_a.size() < 3) begin
      mismatched++;
      $display("FAIL b2b_rd_seen: found=%0d queued=%0d want 1 and 3", found, exp_a.size());
      return;
    end
    compared++;
    if (count_rd(3 * 162 + 8) != 3 || {rd_tr[0], rd_tr[162], rd_tr[324]} !== 3'b111) begin
      mismatched++;
      $display("FAIL b2b_rd_spacing: count=%0d at0/162/324=%b want 3 and 111",
               count_rd(3 * 162 + 8), {rd_tr[0], rd_tr[162], rd_tr[324]});
    end
    for (int f = 0; f < 3; f++) begin
      e = exp_a.pop_front();
      compared++;
      if (decode(162 * f + 2, 16) !== e) begin
        mismatched++;
        $display("FAIL b2b_byte: frame %0d got %h want %h", f, decode(162 * f + 2, 16), e);
      end
      if (f > 0) begin
        compared++;
        if ({tx_tr[162 * f - 1], tx_tr[162 * f], tx_tr[162 * f + 1], tx_tr[162 * f + 2]} !== 4'b1110) begin
          mismatched++;
          $display("FAIL b2b_gap: frame %0d stop/read/load/start=%b want 1110", f,
                   {tx_tr[162 * f - 1], tx_tr[162 * f], tx_tr[162 * f + 1], tx_tr[162 * f + 2]});
        end
      end
    end
    compared++;
    if (underflow_a != 0) begin
      mismatched++;
      $display("FAIL b2b_underflow: got %0d want 0", underflow_a);
    end
  endtask

  task automatic test_enable_gating();
    bit saw_rd = 1'b0, saw_low = 1'b0, found = 1'b0;
    logic [7:0] e;
    @(negedge clk);
    enable_a = 1'b0;
    push_a(8'h5A);
    push_a(8'hC3);
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (fifo_rd_a !== 1'b0) saw_rd = 1'b1;
      if (tx_a !== 1'b1) saw_low = 1'b1;
    end
    compared++;
    if (saw_rd) begin
      mismatched++;
      $display("FAIL gate_no_rd: got strobe while disabled want none");
    end
    compared++;
    if (saw_low) begin
      mismatched++;
      $display("FAIL gate_tx_idle: got tx low while disabled want high");
    end
    enable_a = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (fifo_rd_a === 1'b1) begin
        found = 1'b1;
        break;
      end
    end
    compared++;
    if (!found) begin
      mismatched++;
      $display("FAIL gate_rd_seen: got no strobe want one");
      return;
    end
    for (int i = 0; i < 462; i++) begin
      if (i > 0) @(negedge clk);
      tx_tr[i] = tx_a;
      done_tr[i] = tx_done_a;
      rd_tr[i] = fifo_rd_a;
      busy_tr[i] = busy_a;
      if (i == 2 + 16 * 4 + 8) enable_a = 1'b0;
    end
    e = exp_a.pop_front();
    compared++;
    if (decode(2, 16) !== e) begin
      mismatched++;
      $display("FAIL gate_byte: got %h want %h", decode(2, 16), e);
    end
    compared++;
    if (count_rd(462) != 1 || done_tr[161] !== 1'b1 || busy_tr[162] !== 1'b0) begin
      mismatched++;
      $display("FAIL gate_stop: reads=%0d done_160=%b busy_after=%b want 1,1,0", count_rd(462), done_tr[161], busy_tr[162]);
    end
  endtask

  task automatic test_reset_mid_frame();
    bit found = 1'b0;
    logic [7:0] e;
    enable_a = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (fifo_rd_a === 1'b1) begin
        found = 1'b1;
        break;
      end
    end
    compared++;
    if (!found) begin
      mismatched++;
      $display("FAIL rstmid_rd_seen: got no strobe want one");
      return;
    end
    for (int i = 1; i <= 2 + 16 * 5 + 8; i++) @(negedge clk);
    compared++;
    if (tx_a !== 1'b0 || busy_a !== 1'b1) begin
      mismatched++;
      $display("FAIL rstmid_pre: tx=%b busy=%b in bit 4 want 0 1", tx_a, busy_a);
    end
    #1 rst_n = 1'b0;
    #1;
    compared++;
    if ({tx_a, busy_a, fifo_rd_a, tx_done_a} !== 4'b1000) begin
      mismatched++;
      $display("FAIL rstmid_async: tx/busy/rd/done=%b want 1000", {tx_a, busy_a, fifo_rd_a, tx_done_a});
    end
    e = exp_a.pop_front();
    @(negedge clk);
    @(negedge clk);
    push_a(8'h3C);
    rst_n = 1'b1;
    capture(1'b0, 170, found);
    compared++;
    if (!found) begin
      mismatched++;
      $display("FAIL rstmid_restart: got no strobe after reset want one");
      return;
    end
    e = exp_a.pop_front();
    compared++;
    if ({tx_tr[1], tx_tr[2], tx_tr[17], tx_tr[18]} !== {2'b10, 1'b0, e[0]}) begin
      mismatched++;
      $display("FAIL rstmid_start: load/start_first/start_last/bit0=%b want %b",
               {tx_tr[1], tx_tr[2], tx_tr[17], tx_tr[18]}, {2'b10, 1'b0, e[0]});
    end
    compared++;
    if (decode(2, 16) !== e || done_tr[161] !== 1'b1) begin
      mismatched++;
      $display("FAIL rstmid_byte: got %h done=%b want %h 1", decode(2, 16), done_tr[161], e);
    end
  endtask

  task automatic test_two_stop();
    bit found;
    logic [7:0] e;
    int bad = -1;
    enable_b = 1'b1;
    push_b(8'hFF);
    capture(1'b1, 52, found);
    compared++;
    if (!found || exp_b.size() == 0) begin
      mismatched++;
      $display("FAIL stop2_rd_seen: found=%0d want 1", found);
      return;
    end
    e = exp_b.pop_front();
    for (int i = 0; i < 52; i++) if (tx_tr[i] !== ((i >= 2 && i <= 5) ? 1'b0 : 1'b1)) bad = i;
    compared++;
    if (bad >= 0) begin
      mismatched++;
      $display("FAIL stop2_shape: index %0d got %b", bad, tx_tr[bad]);
    end
    compared++;
    if (count_done(52) != 1 || done_tr[45] !== 1'b1) begin
      mismatched++;
      $display("FAIL stop2_tx_done: count=%0d at_44=%b want 1 and 1", count_done(52), done_tr[45]);
    end
    compared++;
    if ({busy_tr[45], busy_tr[46]} !== 2'b10) begin
      mismatched++;
      $display("FAIL stop2_length: busy at 44/45=%b want 10", {busy_tr[45], busy_tr[46]});
    end
    compared++;
    if (decode(2, 4) !== e || count_rd(52) != 1 || underflow_b != 0) begin
      mismatched++;
      $display("FAIL stop2_byte: got %h reads=%0d underflow=%0d want %h 1 0", decode(2, 4), count_rd(52), underflow_b, e);
    end
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_enable_gating();
    test_reset_mid_frame();
    test_two_stop();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
